// File: rtl/pfa_group_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one GROUP-bit lookahead slice per clock,
// with the inter-slice carry held in a register; also reports word-level P/G.
module pfa_group_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             pg,
   output logic             gg
);

   localparam int NG = WIDTH / GROUP;
   localparam int KW = (NG > 1) ? $clog2(NG) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             c_reg;
   logic [KW-1:0]    k_reg;
   logic             pg_acc_reg;
   logic             gg_acc_reg;
   logic [GROUP-1:0] sum_sl_reg [NG];
   logic             done_reg;
   logic             cout_reg;
   logic             ovf_reg;
   logic             pg_reg;
   logic             gg_reg;

   logic [GROUP-1:0] a_sl [NG];
   logic [GROUP-1:0] b_sl [NG];
   logic [GROUP-1:0] sa;
   logic [GROUP-1:0] sb;
   logic [GROUP-1:0] p;
   logic [GROUP-1:0] g;
   logic [GROUP-1:0] s;
   logic [GROUP:0]   c;
   logic             gen_v;
   logic             prop_v;
   logic             slice_gp;
   logic             slice_gg;

   genvar gi;
   generate
      for (gi = 0; gi < NG; gi++) begin : g_slice
         assign a_sl[gi]                  = a_reg[gi*GROUP +: GROUP];
         assign b_sl[gi]                  = b_reg[gi*GROUP +: GROUP];
         assign sum[gi*GROUP +: GROUP]    = sum_sl_reg[gi];
      end
   endgenerate

   assign sa = a_sl[k_reg];
   assign sb = b_sl[k_reg];

   generate
      for (gi = 0; gi < GROUP; gi++) begin : g_pfa
         assign p[gi] = sa[gi] | sb[gi];
         assign g[gi] = sa[gi] & sb[gi];
         assign s[gi] = sa[gi] ^ sb[gi] ^ c[gi];
      end
   endgenerate

   // Each carry is a flat sum-of-products of the slice-entry carry, never rippled.
   always_comb begin
      c      = '0;
      c[0]   = c_reg;
      gen_v  = 1'b0;
      prop_v = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
         gen_v  = g[j];
         prop_v = p[j];
         for (int m = j - 1; m >= 0; m--) begin
            gen_v  = gen_v | (prop_v & g[m]);
            prop_v = prop_v & p[m];
         end
         c[j+1] = gen_v | (prop_v & c_reg);
      end
      slice_gg = gen_v;
      slice_gp = &p;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         c_reg      <= 1'b0;
         k_reg      <= '0;
         pg_acc_reg <= 1'b0;
         gg_acc_reg <= 1'b0;
         done_reg   <= 1'b0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         pg_reg     <= 1'b0;
         gg_reg     <= 1'b0;
         for (int i = 0; i < NG; i++) sum_sl_reg[i] <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  a_reg      <= a;
                  b_reg      <= sub ? ~b : b;
                  c_reg      <= cin ^ sub;
                  k_reg      <= '0;
                  pg_acc_reg <= 1'b1;
                  gg_acc_reg <= 1'b0;
                  state_reg  <= S_RUN;
               end
            end
            S_RUN: begin
               sum_sl_reg[k_reg] <= s;
               pg_acc_reg        <= pg_acc_reg & slice_gp;
               gg_acc_reg        <= slice_gg | (slice_gp & gg_acc_reg);
               c_reg             <= c[GROUP];
               if (k_reg == KW'(NG - 1)) begin
                  k_reg     <= '0;
                  cout_reg  <= c[GROUP];
                  ovf_reg   <= c[GROUP] ^ c[GROUP-1];
                  pg_reg    <= pg_acc_reg & slice_gp;
                  gg_reg    <= slice_gg | (slice_gp & gg_acc_reg);
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  k_reg <= k_reg + 1'b1;
               end
            end
            S_DONE: begin
               done_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign ready = (state_reg == S_IDLE);
   assign done  = done_reg;
   assign cout  = cout_reg;
   assign ovf   = ovf_reg;
   assign pg    = pg_reg;
   assign gg    = gg_reg;

endmodule

// File: tb/tb_pfa_group_adder.sv
// Directed and random checks of pfa_group_adder at 16/4, 8/1 and 32/8.
module tb_pfa_group_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        cin_in;
   logic        sub_in;
   logic        start8, start16, start32;

   logic        ready8, done8, cout8, ovf8, pg8, gg8;
   logic [7:0]  sum8;
   logic        ready16, done16, cout16, ovf16, pg16, gg16;
   logic [15:0] sum16;
   logic        ready32, done32, cout32, ovf32, pg32, gg32;
   logic [31:0] sum32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pfa_group_adder #(.WIDTH(16), .GROUP(4)) u16 (
      .clk(clk), .rst(rst), .start(start16), .a(a_in[15:0]), .b(b_in[15:0]),
      .cin(cin_in), .sub(sub_in), .ready(ready16), .done(done16), .sum(sum16),
      .cout(cout16), .ovf(ovf16), .pg(pg16), .gg(gg16));

   pfa_group_adder #(.WIDTH(8), .GROUP(1)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a_in[7:0]), .b(b_in[7:0]),
      .cin(cin_in), .sub(sub_in), .ready(ready8), .done(done8), .sum(sum8),
      .cout(cout8), .ovf(ovf8), .pg(pg8), .gg(gg8));

   pfa_group_adder #(.WIDTH(32), .GROUP(8)) u32 (
      .clk(clk), .rst(rst), .start(start32), .a(a_in), .b(b_in),
      .cin(cin_in), .sub(sub_in), .ready(ready32), .done(done32), .sum(sum32),
      .cout(cout32), .ovf(ovf32), .pg(pg32), .gg(gg32));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic sel_ready(input int w);
      case (w)
         8:       return ready8;
         16:      return ready16;
         default: return ready32;
      endcase
   endfunction

   function automatic logic sel_done(input int w);
      case (w)
         8:       return done8;
         16:      return done16;
         default: return done32;
      endcase
   endfunction

   task automatic set_start(input int w, input logic v);
      start8  = (w == 8)  ? v : 1'b0;
      start16 = (w == 16) ? v : 1'b0;
      start32 = (w == 32) ? v : 1'b0;
   endtask

   // Waits for ready, launches one op, returns edges from acceptance to done.
   task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic su, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!sel_ready(w) && n < 100) begin
         @(negedge clk);
         n++;
      end
      a_in = av; b_in = bv; cin_in = ci; sub_in = su;
      set_start(w, 1'b1);
      @(posedge clk);
      #1;
      set_start(w, 1'b0);
      check("ready_low_after_accept", 32'(sel_ready(w)), 32'd1 - 32'd1);
      lat = 1;
      while (!sel_done(w) && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      $display("op w=%0d a=%h b=%h cin=%0b sub=%0b latency=%0d", w, av, bv, ci, su, lat);
   endtask

   initial begin
      int          lat;
      int          n;
      logic [6:0]  rdy_pat;
      logic [6:0]  done_pat;
      logic [31:0] av, bv, bb;
      logic        ci, su, c0;
      logic [32:0] full, low, gen;

      rst = 1'b1;
      a_in = 32'h0; b_in = 32'h0; cin_in = 1'b0; sub_in = 1'b0;
      set_start(16, 1'b1);
      start8 = 1'b1; start32 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(ready16), 32'd1);
      check("rst_done",  32'(done16),  32'd0);
      check("rst_sum",   32'(sum16),   32'h0);
      check("rst_cout_ovf_pg_gg", {28'h0, cout16, ovf16, pg16, gg16}, 32'h0);
      rst = 1'b0;
      set_start(0, 1'b0);
      @(posedge clk);
      #1;
      check("rst_no_start", 32'(ready16), 32'd1);

      run_op(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0, lat);
      check("wrap_latency", 32'(lat), 32'd5);
      check("wrap_sum", 32'(sum16), 32'h0000);
      check("wrap_flags", {28'h0, cout16, ovf16, pg16, gg16}, 32'b1011);

      run_op(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0, lat);
      check("ovf_sum", 32'(sum16), 32'h8000);
      check("ovf_flags", {28'h0, cout16, ovf16, pg16, gg16}, 32'b0100);
      @(posedge clk);
      #1;
      check("ovf_done_one_cycle", 32'(done16), 32'd0);

      run_op(16, 32'h0005, 32'h0007, 1'b0, 1'b1, lat);
      check("sub_sum", 32'(sum16), 32'hFFFE);
      check("sub_flags", {28'h0, cout16, ovf16, pg16, gg16}, 32'b0000);

      run_op(16, 32'h0005, 32'h0007, 1'b1, 1'b1, lat);
      check("sub_borrow_sum", 32'(sum16), 32'hFFFD);
      check("sub_borrow_cout_ovf", {30'h0, cout16, ovf16}, 32'b00);

      // start held high continuously: one accept, re-accept on the first IDLE cycle
      n = 0;
      @(negedge clk);
      while (!ready16 && n < 20) begin
         @(negedge clk);
         n++;
      end
      a_in = 32'h0003; b_in = 32'h0004; cin_in = 1'b0; sub_in = 1'b0;
      start16 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         #1;
         rdy_pat[i]  = ready16;
         done_pat[i] = done16;
      end
      start16 = 1'b0;
      $display("handshake ready_pat=%b done_pat=%b", rdy_pat, done_pat);
      check("hs_ready_pattern", 32'(rdy_pat), 32'b0100000);
      check("hs_done_pattern",  32'(done_pat), 32'b0010000);
      n = 0;
      while (!done16 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("hs_second_done", 32'(done16), 32'd1);
      check("hs_second_sum", 32'(sum16), 32'h0007);

      // abort with reset once two slices have been processed
      n = 0;
      @(negedge clk);
      while (!ready16 && n < 20) begin
         @(negedge clk);
         n++;
      end
      a_in = 32'h1234; b_in = 32'h1111; cin_in = 1'b1; sub_in = 1'b0;
      start16 = 1'b1;
      @(posedge clk);
      #1;
      start16 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_ready", 32'(ready16), 32'd1);
      check("abort_done", 32'(done16), 32'd0);
      check("abort_sum", 32'(sum16), 32'h0);
      check("abort_flags", {28'h0, cout16, ovf16, pg16, gg16}, 32'h0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done16) n++;
      end
      check("abort_no_done", 32'(n), 32'd0);
      $display("abort done_pulses=%0d", n);

      run_op(8, 32'hAA, 32'h55, 1'b1, 1'b0, lat);
      check("g1_latency", 32'(lat), 32'd9);
      check("g1_sum", 32'(sum8), 32'h00);
      check("g1_flags", {28'h0, cout8, ovf8, pg8, gg8}, 32'b1010);

      for (int t = 0; t < 1000; t++) begin
         av = $urandom;
         bv = $urandom;
         ci = 1'($urandom_range(0, 1));
         su = 1'($urandom_range(0, 1));
         bb = su ? ~bv : bv;
         c0 = ci ^ su;
         full = {1'b0, av} + {1'b0, bb} + {32'h0, c0};
         low  = {2'b0, av[30:0]} + {2'b0, bb[30:0]} + {32'h0, c0};
         gen  = {1'b0, av} + {1'b0, bb};
         run_op(32, av, bv, ci, su, lat);
         check("r32_latency", 32'(lat), 32'd5);
         check("r32_sum", sum32, full[31:0]);
         check("r32_cout", 32'(cout32), 32'(full[32]));
         check("r32_ovf", 32'(ovf32), 32'(full[32] ^ low[31]));
         check("r32_pg", 32'(pg32), 32'(&(av | bb)));
         check("r32_gg", 32'(gg32), 32'(gen[32]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
